// File: rtl/conv_pkg.sv
// Shared types and helpers for the sequential-channel KxK convolution core.
// Accumulator sizing and output range reduction live here so every instance agrees on them.
package conv_pkg;

    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_OUT   = 2'd2
    } conv_state_e;

    // Widest value sat_trunc handles; accumulator widths must stay at or below this.
    localparam int SAT_W = 128;

    function automatic int acc_width(input int dw, input int rw, input int k, input int nc);
        int prod_w;
        prod_w = 2 * dw + $clog2(k * k * nc);
        return ((rw > prod_w) ? rw : prod_w) + 1;
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_trunc(input logic signed [SAT_W-1:0] value,
                                                          input int rw, input bit saturate);
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        logic signed [SAT_W-1:0] res;
        max_v = (SAT_W'(1) <<< (rw - 1)) - SAT_W'(1);
        min_v = -max_v - SAT_W'(1);
        if (saturate) begin
            if (value > max_v) begin
                res = max_v;
            end else if (value < min_v) begin
                res = min_v;
            end else begin
                res = value;
            end
        end else begin
            // Keep the low rw bits, sign-extended from bit rw-1.
            res = (value <<< (SAT_W - rw)) >>> (SAT_W - rw);
        end
        return res;
    endfunction

endpackage

// File: rtl/conv_window_mac.sv
// Combinational signed dot product of one KxK window against one KxK kernel.
// Products are kept at full 2*DATA_WIDTH precision and sign-extended into OUT_WIDTH.
module conv_window_mac
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int KSIZE      = 3,
    parameter int OUT_WIDTH  = 22
) (
    input  logic [KSIZE-1:0][KSIZE-1:0][DATA_WIDTH-1:0] data_in,
    input  logic [KSIZE-1:0][KSIZE-1:0][DATA_WIDTH-1:0] kernel,
    output logic [OUT_WIDTH-1:0]                        dot
);

    localparam int PW = 2 * DATA_WIDTH;

    logic signed [PW-1:0]        prod_s;
    logic signed [OUT_WIDTH-1:0] sum_s;

    always_comb begin
        prod_s = '0;
        sum_s  = '0;
        for (int r = 0; r < KSIZE; r++) begin
            for (int c = 0; c < KSIZE; c++) begin
                prod_s = PW'($signed(data_in[r][c])) * PW'($signed(kernel[r][c]));
                sum_s  = sum_s + OUT_WIDTH'(prod_s);
            end
        end
    end

    assign dot = sum_s;

endmodule

// File: rtl/conv_kxk_seq_channel_core.sv
// One output pixel = bias + sum over channels of a KxK dot product, one channel per beat.
// ACC collects beats, FLUSH folds in the last partial and shapes the result, OUT holds it.
module conv_kxk_seq_channel_core
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int RESULT_WIDTH = 24,
    parameter int KSIZE        = 3,
    parameter int NUM_CHANNELS = 3,
    parameter int SATURATE     = 1
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [KSIZE-1:0][KSIZE-1:0][DATA_WIDTH-1:0] data_in,
    input  logic [KSIZE-1:0][KSIZE-1:0][DATA_WIDTH-1:0] kernel,
    input  logic [RESULT_WIDTH-1:0]                     bias,
    input  logic                                        relu_en,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [RESULT_WIDTH-1:0]                     result,
    output logic                                        busy
);

    localparam int ACC_W = acc_width(DATA_WIDTH, RESULT_WIDTH, KSIZE, NUM_CHANNELS);
    localparam int CNT_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(NUM_CHANNELS - 1);

    conv_state_e               state_q, state_d;
    logic [CNT_W-1:0]          ch_cnt_q, ch_cnt_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [ACC_W-1:0]   psum_q, psum_d;
    logic                      psum_v_q, psum_v_d;
    logic                      relu_q, relu_d;
    logic [RESULT_WIDTH-1:0]   result_q, result_d;
    logic                      out_valid_q, out_valid_d;

    logic [ACC_W-1:0]          mac_s;
    logic                      beat_s;
    logic signed [ACC_W-1:0]   final_s;
    logic signed [ACC_W-1:0]   relu_val_s;
    logic signed [SAT_W-1:0]   sat_s;

    conv_window_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .KSIZE      (KSIZE),
        .OUT_WIDTH  (ACC_W)
    ) u_mac (
        .data_in (data_in),
        .kernel  (kernel),
        .dot     (mac_s)
    );

    assign in_ready  = (state_q == ST_ACC);
    assign busy      = !((state_q == ST_ACC) && (ch_cnt_q == '0));
    assign out_valid = out_valid_q;
    assign result    = result_q;

    always_comb begin
        state_d     = state_q;
        ch_cnt_d    = ch_cnt_q;
        psum_d      = psum_q;
        psum_v_d    = 1'b0;
        relu_d      = relu_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        beat_s      = in_valid && in_ready;
        acc_d       = psum_v_q ? (acc_q + psum_q) : acc_q;
        final_s     = acc_q + psum_q;
        relu_val_s  = (relu_q && final_s[ACC_W-1]) ? '0 : final_s;
        sat_s       = sat_trunc(SAT_W'(relu_val_s), RESULT_WIDTH, SATURATE != 0);

        case (state_q)
            ST_ACC: begin
                if (beat_s) begin
                    psum_d   = $signed(mac_s);
                    psum_v_d = 1'b1;
                    // The previous pixel drained in FLUSH, so no pending psum collides with the bias load.
                    if (ch_cnt_q == '0) begin
                        acc_d  = ACC_W'($signed(bias));
                        relu_d = relu_en;
                    end
                    if (ch_cnt_q == LAST_CH) begin
                        ch_cnt_d = '0;
                        state_d  = ST_FLUSH;
                    end else begin
                        ch_cnt_d = ch_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_FLUSH: begin
                result_d    = sat_s[RESULT_WIDTH-1:0];
                out_valid_d = 1'b1;
                state_d     = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_ACC;
                end
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ACC;
            ch_cnt_q    <= '0;
            acc_q       <= '0;
            psum_q      <= '0;
            psum_v_q    <= 1'b0;
            relu_q      <= 1'b0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_cnt_q    <= ch_cnt_d;
            acc_q       <= acc_d;
            psum_q      <= psum_d;
            psum_v_q    <= psum_v_d;
            relu_q      <= relu_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
